// File: rtl/demux1_to_4_stream_pkg.sv
// demux1_to_4_stream_pkg: shared channel count, select width and channel codes
package demux_pkg;
    localparam int NumCh = 4;
    localparam int SelW = 2;
    localparam logic [SelW-1:0] SEL_CH1 = 2'd0;
    localparam logic [SelW-1:0] SEL_CH2 = 2'd1;
    localparam logic [SelW-1:0] SEL_CH3 = 2'd2;
    localparam logic [SelW-1:0] SEL_CH4 = 2'd3;
endpackage

// File: rtl/demux1_to_4_stream_if.sv
// demux1_to_4_stream_if: producer stream plus four consumer channels
interface demux1_to_4_stream_if
    import demux_pkg::*;
#(
    parameter int Width = 32
);
    logic [Width-1:0] data_i;
    logic [SelW-1:0]  sel_i;
    logic             valid_i;
    logic             ready_o;
    logic [Width-1:0] data1_o, data2_o, data3_o, data4_o;
    logic             valid1_o, valid2_o, valid3_o, valid4_o;
    logic             ready1_i, ready2_i, ready3_i, ready4_i;

    modport slave (
        input  data_i, sel_i, valid_i, ready1_i, ready2_i, ready3_i, ready4_i,
        output ready_o, data1_o, data2_o, data3_o, data4_o,
               valid1_o, valid2_o, valid3_o, valid4_o
    );

    modport master (
        output data_i, sel_i, valid_i, ready1_i, ready2_i, ready3_i, ready4_i,
        input  ready_o, data1_o, data2_o, data3_o, data4_o,
               valid1_o, valid2_o, valid3_o, valid4_o
    );
endinterface

// File: rtl/demux1_to_4_stream_slot.sv
// stream_slot: one-entry output register that can drain and reload in the same cycle
module stream_slot #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o,
    input  logic             ready_i,
    output logic             free_o
);
    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;

    assign free_o  = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // load wins over drain; data is kept on drain and only cleared by reset
    always_comb begin
        valid_d = load_i || (valid_q && !ready_i);
        data_d  = load_i ? data_i : data_q;
    end

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/demux1_to_4_stream.sv
// demux1_to_4_stream: steers each accepted word to one of four registered channels
module demux1_to_4_stream
    import demux_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    demux1_to_4_stream_if.slave   bus
);
    logic [NumCh-1:0] load, free, valid, ready;
    logic [Width-1:0] data [NumCh];
    logic             accept;

    assign ready       = {bus.ready4_i, bus.ready3_i, bus.ready2_i, bus.ready1_i};
    assign bus.ready_o = free[bus.sel_i];
    assign accept      = bus.valid_i && free[bus.sel_i];

    // 2-to-4 decode of the destination, gated by the input handshake
    always_comb begin
        load[0] = accept && bus.sel_i == SEL_CH1;
        load[1] = accept && bus.sel_i == SEL_CH2;
        load[2] = accept && bus.sel_i == SEL_CH3;
        load[3] = accept && bus.sel_i == SEL_CH4;
    end

    for (genvar g = 0; g < NumCh; g++) begin : g_slot
        stream_slot #(.Width(Width)) u_slot (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .load_i  (load[g]),
            .data_i  (bus.data_i),
            .valid_o (valid[g]),
            .data_o  (data[g]),
            .ready_i (ready[g]),
            .free_o  (free[g])
        );
    end

    assign bus.valid1_o = valid[0];
    assign bus.valid2_o = valid[1];
    assign bus.valid3_o = valid[2];
    assign bus.valid4_o = valid[3];
    assign bus.data1_o  = data[0];
    assign bus.data2_o  = data[1];
    assign bus.data3_o  = data[2];
    assign bus.data4_o  = data[3];
endmodule

// File: tb/tb_demux1_to_4_stream.sv
// tb_demux1_to_4_stream: directed scenarios plus random traffic against per-channel queues
module tb_demux1_to_4_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux1_to_4_stream_if #(.Width(32)) bus ();

    demux1_to_4_stream #(.Width(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    assert property (@(posedge clk) disable iff (rst)
        (bus.valid_i && !bus.ready_o) |=> (bus.valid_i && $stable(bus.data_i) && $stable(bus.sel_i)));

    function automatic logic getv(int n);
        return n == 0 ? bus.valid1_o : n == 1 ? bus.valid2_o : n == 2 ? bus.valid3_o : bus.valid4_o;
    endfunction

    function automatic logic [31:0] getd(int n);
        return n == 0 ? bus.data1_o : n == 1 ? bus.data2_o : n == 2 ? bus.data3_o : bus.data4_o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d);
        bus.valid_i = v;
        bus.sel_i   = s;
        bus.data_i  = d;
    endtask

    task automatic set_rdy(input logic [3:0] r);
        {bus.ready4_i, bus.ready3_i, bus.ready2_i, bus.ready1_i} = r;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        drive(1'b0, 2'd0, 32'h0);
        set_rdy(4'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("reset_valid%0d", n + 1), 32'(getv(n)), 32'h0);
            chk($sformatf("reset_data%0d", n + 1), getd(n), 32'h0);
        end
        #1 chk("reset_ready", 32'(bus.ready_o), 32'h1);
    endtask

    task automatic test_reset_mid_traffic();
        do_reset();
        drive(1'b1, 2'd1, 32'hA5A5_0001);
        step();
        drive(1'b0, 2'd1, 32'h0);
        chk("mid_loaded_valid2", 32'(bus.valid2_o), 32'h1);
        chk("mid_loaded_data2", bus.data2_o, 32'hA5A5_0001);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int n = 0; n < 4; n++) chk($sformatf("mid_valid%0d", n + 1), 32'(getv(n)), 32'h0);
        chk("mid_data2", bus.data2_o, 32'h0);
        #1 chk("mid_ready", 32'(bus.ready_o), 32'h1);
    endtask

    task automatic test_single();
        do_reset();
        drive(1'b1, 2'd2, 32'h0000_CAFE);
        step();
        drive(1'b0, 2'd0, 32'h0);
        chk("single_valid3", 32'(bus.valid3_o), 32'h1);
        chk("single_data3", bus.data3_o, 32'h0000_CAFE);
        chk("single_valid1", 32'(bus.valid1_o), 32'h0);
        chk("single_valid2", 32'(bus.valid2_o), 32'h0);
        chk("single_valid4", 32'(bus.valid4_o), 32'h0);
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, 2'd0, 32'h11);
        step();
        drive(1'b1, 2'd0, 32'h22);
        #1 chk("bp_ready_low", 32'(bus.ready_o), 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_data1", bus.data1_o, 32'h11);
            chk("bp_hold_ready", 32'(bus.ready_o), 32'h0);
        end
        set_rdy(4'b0001);
        #1 chk("bp_ready_release", 32'(bus.ready_o), 32'h1);
        step();
        drive(1'b0, 2'd0, 32'h0);
        set_rdy(4'h0);
        chk("bp_data1_new", bus.data1_o, 32'h22);
        chk("bp_valid1_new", 32'(bus.valid1_o), 32'h1);
    endtask

    task automatic test_independence();
        do_reset();
        drive(1'b1, 2'd3, 32'h44);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'(i), 32'(i + 1));
            #1 chk("ind_ready", 32'(bus.ready_o), 32'h1);
            step();
        end
        drive(1'b0, 2'd0, 32'h0);
        for (int n = 0; n < 3; n++) chk($sformatf("ind_data%0d", n + 1), getd(n), 32'(n + 1));
        chk("ind_valid4", 32'(bus.valid4_o), 32'h1);
        chk("ind_data4", bus.data4_o, 32'h44);
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_rdy(4'b0010);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'd1, 32'(i));
            #1 chk("b2b_ready", 32'(bus.ready_o), 32'h1);
            step();
            chk("b2b_data2", bus.data2_o, 32'(i));
            chk("b2b_valid2", 32'(bus.valid2_o), 32'h1);
        end
        drive(1'b0, 2'd0, 32'h0);
        set_rdy(4'h0);
    endtask

    task automatic test_random();
        logic [31:0] q [4][$];
        logic [3:0]  rdy;
        logic        hold = 1'b0;
        logic        exp_rdy;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            rdy = 4'($urandom);
            set_rdy(rdy);
            if (!hold) drive($urandom_range(0, 3) != 0, 2'($urandom), $urandom);
            #1;
            exp_rdy = q[bus.sel_i].size() == 0 || rdy[bus.sel_i];
            for (int n = 0; n < 4; n++) begin
                chk($sformatf("rnd_valid%0d", n + 1), 32'(getv(n)), 32'(q[n].size() != 0));
                if (q[n].size() != 0) chk($sformatf("rnd_data%0d", n + 1), getd(n), q[n][0]);
            end
            chk("rnd_ready", 32'(bus.ready_o), 32'(exp_rdy));
            for (int n = 0; n < 4; n++) if (q[n].size() != 0 && rdy[n]) void'(q[n].pop_front());
            if (bus.valid_i && exp_rdy) q[bus.sel_i].push_back(bus.data_i);
            hold = bus.valid_i && !exp_rdy;
            step();
        end
        drive(1'b0, 2'd0, 32'h0);
        set_rdy(4'h0);
    endtask

    initial begin
        drive(1'b0, 2'd0, 32'h0);
        set_rdy(4'h0);
        test_reset();
        test_reset_mid_traffic();
        test_single();
        test_backpressure();
        test_independence();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
